// File: rtl/io_controller_if.sv
// io_controller_if: CPU req/ack bus between the SCIC CPU and the I/O controller
interface io_controller_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic req;
  logic we;
  logic [1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic ack;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/io_controller.sv
// io_controller: memory-mapped debounced switches and LED register; define IO_IRQ_EN for the change irq
module io_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int IO_WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  io_controller_if.slave bus,
  input  logic [IO_WIDTH-1:0] switches,
  output logic [IO_WIDTH-1:0] LEDs
`ifdef IO_IRQ_EN
  , output logic irq
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nxt;
  logic we_q;
  logic [1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rd;
  logic [IO_WIDTH-1:0] sync1, sync2, stable, wr_io;
  logic [CW-1:0] cnt;
  logic flag, irq_en, acc, accept, st_clear, unused_wdata;
  assign acc = state == ACCESS;
  assign wr_io = wdata_q[IO_WIDTH-1:0];
  assign unused_wdata = ^wdata_q;
  assign accept = sync2 != stable && cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign st_clear = acc && !we_q && addr_q == 2'd2;
  assign rd = addr_q == 2'd0 ? DATA_WIDTH'(stable) :
              addr_q == 2'd1 ? DATA_WIDTH'(LEDs) :
              addr_q == 2'd2 ? DATA_WIDTH'({irq_en, flag}) : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (bus.req ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
    bus.ack = state == DONE;
    bus.rdata = state == DONE ? rdata_q : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && bus.req) begin
      we_q <= bus.we;
      addr_q <= bus.addr;
      wdata_q <= bus.wdata;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rdata_q <= '0;
      LEDs <= '0;
    end else if (acc) begin
      rdata_q <= we_q ? '0 : rd;
      if (we_q && addr_q == 2'd1) LEDs <= wr_io;
      if (we_q && addr_q == 2'd3) LEDs <= LEDs ^ wr_io;
    end
  // counter only runs while the synchronised input disagrees with the accepted value
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      cnt <= '0;
      flag <= 1'b0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      cnt <= sync2 == stable || accept ? '0 : cnt + CW'(1);
      if (accept) stable <= sync2;
      flag <= accept || (flag && !st_clear);
    end
`ifdef IO_IRQ_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (acc && we_q && addr_q == 2'd2) irq_en <= wdata_q[1];
      irq <= flag && irq_en;
    end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: scoreboard bench for io_controller with DEBOUNCE_CYCLES=4
`timescale 1ns/1ps
module tb_io_controller;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int DB = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [IW-1:0] switches = '0;
  logic [IW-1:0] leds;
`ifdef IO_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int errors = 0;
  int acks = 0;
  logic [8:0] exp_q[$];
  logic [IW-1:0] led_m = '0;
  io_controller_if #(.DATA_WIDTH(DW)) bus ();
  io_controller #(.DATA_WIDTH(DW), .IO_WIDTH(IW), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .switches(switches),
    .LEDs(leds)
`ifdef IO_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clock = ~clock;
  // scoreboard: each ack pops the oldest expectation ({care, rdata})
  always @(negedge clock) begin
    logic [8:0] e;
    if (bus.ack === 1'b1) begin
      acks++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack rdata=%h", bus.rdata);
      end else begin
        e = exp_q.pop_front();
        if (e[8] && bus.rdata !== e[7:0]) begin
          errors++;
          $display("FAIL rdata got=%h exp=%h", bus.rdata, e[7:0]);
        end
      end
    end else if (!reset) begin
      checks++;
      if (bus.rdata !== '0) begin
        errors++;
        $display("FAIL idle_rdata got=%h exp=00", bus.rdata);
      end
    end
  end
  task automatic access(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
    int n;
    logic got;
    exp_q.push_back({~w, exp});
    @(negedge clock);
    bus.req = 1'b1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (bus.ack === 1'b1) got = 1'b1;
    end
    bus.req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout addr=%0d", a);
      exp_q.delete();
    end else if (n != 2) begin
      errors++;
      $display("FAIL ack_latency got=%0d exp=2", n);
    end
    if (w && a == 2'd1) led_m = d[IW-1:0];
    if (w && a == 2'd3) led_m = led_m ^ d[IW-1:0];
    checks++;
    if (leds !== led_m) begin
      errors++;
      $display("FAIL leds got=%b exp=%b", leds, led_m);
    end
  endtask
  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (leds !== '0 || bus.ack !== 1'b0 || bus.rdata !== '0) begin
      errors++;
      $display("FAIL reset_state leds=%b ack=%b rdata=%h exp 0", leds, bus.ack, bus.rdata);
    end
    access(1'b0, 2'd2, 8'h00, 8'h00);
  endtask
  task automatic test_write_read();
    access(1'b1, 2'd1, 8'hA5, 8'h00);
    access(1'b0, 2'd1, 8'h00, 8'h05);
  endtask
  task automatic test_debounce();
    @(negedge clock);
    switches = 4'b0110;
    repeat (10) @(negedge clock);
    access(1'b0, 2'd0, 8'h00, 8'h06);
    access(1'b0, 2'd2, 8'h00, 8'h01);
    access(1'b0, 2'd2, 8'h00, 8'h00);
  endtask
  task automatic test_glitch();
    @(negedge clock);
    switches = 4'b0000;
    repeat (10) @(negedge clock);
    access(1'b0, 2'd2, 8'h00, 8'h01);
    access(1'b0, 2'd0, 8'h00, 8'h00);
    @(negedge clock);
    switches = 4'b0001;
    repeat (2) @(negedge clock);
    switches = 4'b0000;
    repeat (10) @(negedge clock);
    access(1'b0, 2'd0, 8'h00, 8'h00);
    access(1'b0, 2'd2, 8'h00, 8'h00);
  endtask
  task automatic test_back_to_back();
    int first;
    int second;
    access(1'b1, 2'd3, 8'h0F, 8'h00);
    first = -1;
    second = -1;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    @(negedge clock);
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.addr = 2'd3;
    bus.wdata = 8'h0F;
    for (int i = 1; i <= 20 && second < 0; i++) begin
      @(negedge clock);
      if (bus.ack === 1'b1) begin
        if (first < 0) first = i;
        else begin
          second = i;
          bus.req = 1'b0;
        end
        led_m = led_m ^ 4'hF;
        checks++;
        if (leds !== led_m) begin
          errors++;
          $display("FAIL b2b_leds got=%b exp=%b", leds, led_m);
        end
      end
    end
    bus.req = 1'b0;
    checks++;
    if (first < 0 || second < 0 || second - first != 3) begin
      errors++;
      $display("FAIL b2b_spacing first=%0d second=%0d exp gap 3", first, second);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset_abort();
    int snap;
    snap = acks;
    @(negedge clock);
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.addr = 2'd1;
    bus.wdata = 8'h0F;
    @(posedge clock);
    #2;
    reset = 1'b1;
    bus.req = 1'b0;
    led_m = '0;
    @(negedge clock);
    checks++;
    if (leds !== '0 || bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset leds=%b ack=%b exp 0000/0", leds, bus.ack);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (acks != snap || leds !== '0) begin
      errors++;
      $display("FAIL abort_no_ack acks=%0d exp=%0d leds=%b exp 0000", acks, snap, leds);
    end
  endtask
  task automatic test_status_irq();
    access(1'b1, 2'd2, 8'h02, 8'h00);
    @(negedge clock);
    switches = 4'b1000;
    repeat (10) @(negedge clock);
`ifdef IO_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got=%b exp=1", irq);
    end
    access(1'b0, 2'd2, 8'h00, 8'h03);
    repeat (2) @(negedge clock);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
`else
    access(1'b0, 2'd2, 8'h00, 8'h01);
`endif
    access(1'b0, 2'd3, 8'h00, 8'h00);
    access(1'b0, 2'd0, 8'h00, 8'h08);
  endtask
  initial begin
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    #7 reset = 1'b0;
    test_reset();
    test_write_read();
    test_debounce();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    test_status_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
